fec_encoder: RTL and testbench

Clause-74-style FEC encoder for the 10GBASE-KR transmit path, the counterpart of the receive-side FEC decoder/corrector. It accepts a stream of 65-bit transcoded blocks arriving in a 33-cycle cadence: 32 data cycles followed by one idle gap. It computes the 32-bit (2112,2080) cyclic parity over each 32-block frame and inserts that parity into the gap cycle. PN-2112 scrambling and gearboxing are handled downstream and are out of scope.

---
 rtl/fec_if.sv | 25 ++
 rtl/fec_encoder.sv | 156 +++++++++++++++
 tb/tb_fec_encoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fec_if.sv
// Block stream bundle between the transcoder and the FEC encoder.
// The master drives D_* blocks in; the slave returns E_* blocks out.
interface fec_if;
  logic        D_BLK_ENA;
  logic [64:0] D_BLK;
  logic        E_BLK_ENA;
  logic [64:0] E_BLK;
  logic        E_BLK_PAR;

  modport master (
    output D_BLK_ENA,
    output D_BLK,
    input  E_BLK_ENA,
    input  E_BLK,
    input  E_BLK_PAR
  );

  modport slave (
    input  D_BLK_ENA,
    input  D_BLK,
    output E_BLK_ENA,
    output E_BLK,
    output E_BLK_PAR
  );
endinterface

// File: rtl/fec_encoder.sv
// 10GBASE-KR (2112,2080) FEC encoder: passes 32 blocks per frame and
// drops the 32-bit cyclic parity into the idle gap cycle.
module fec_encoder #(
  parameter logic [31:0] G_POLY     = 32'h00A0_0805,
  parameter int          FRAME_BLKS = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENC_EN,
  input  logic        CSR_CLR,
  fec_if.slave        bus,
  output logic        CSR_STAT_ENC_LOCK,
  output logic        CSR_ERR_CADENCE,
  output logic [31:0] CSR_FRAME_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  localparam logic [5:0] LP_LAST = 6'(FRAME_BLKS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_adv;
  logic [31:0] w_lfsr_nxt;
  logic [31:0] w_par;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic        w_ena_nxt;
  logic [64:0] w_blk_nxt;
  logic        w_par_nxt;
  logic        w_inc;
  logic        w_err;

  // 65 serial division steps, D_BLK[0] first
  always_comb begin
    w_lfsr_adv = r_lfsr;
    for (int i = 0; i < 65; i++) begin
      w_lfsr_adv = {w_lfsr_adv[30:0], 1'b0}
        ^ ({32{bus.D_BLK[i] ^ w_lfsr_adv[31]}} & G_POLY);
    end
  end

  // highest-degree remainder term goes out first
  always_comb begin
    w_par = '0;
    for (int k = 0; k < 32; k++) begin
      w_par[k] = r_lfsr[31-k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_ena_nxt   = 1'b0;
    w_blk_nxt   = bus.D_BLK;
    w_par_nxt   = 1'b0;
    w_inc       = 1'b0;
    w_err       = 1'b0;
    if (!ENC_EN) begin
      w_state_nxt = IDLE;
      w_ena_nxt   = bus.D_BLK_ENA;
      w_lfsr_nxt  = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = ALIGN;
          w_ena_nxt   = bus.D_BLK_ENA;
          w_lfsr_nxt  = '0;
          w_cnt_nxt   = '0;
        end
        ALIGN: begin
          w_lfsr_nxt = '0;
          w_cnt_nxt  = '0;
          if (!bus.D_BLK_ENA) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          unique case (1'b1)
            (bus.D_BLK_ENA && r_cnt != LP_LAST): begin
              w_ena_nxt  = 1'b1;
              w_lfsr_nxt = w_lfsr_adv;
              w_cnt_nxt  = r_cnt + 6'd1;
            end
            (!bus.D_BLK_ENA && r_cnt == LP_LAST): begin
              w_ena_nxt  = 1'b1;
              w_blk_nxt  = {33'h0, w_par};
              w_par_nxt  = 1'b1;
              w_lfsr_nxt = '0;
              w_cnt_nxt  = '0;
              w_inc      = 1'b1;
            end
            default: begin
              w_err       = 1'b1;
              w_state_nxt = ALIGN;
              w_lfsr_nxt  = '0;
              w_cnt_nxt   = '0;
            end
          endcase
        end
        default: begin
          w_state_nxt = IDLE;
          w_lfsr_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lfsr            <= '0;
      r_cnt             <= '0;
      bus.E_BLK_ENA     <= 1'b0;
      bus.E_BLK         <= '0;
      bus.E_BLK_PAR     <= 1'b0;
      CSR_STAT_ENC_LOCK <= 1'b0;
      CSR_ERR_CADENCE   <= 1'b0;
      CSR_FRAME_CNT     <= '0;
    end else begin
      r_lfsr            <= w_lfsr_nxt;
      r_cnt             <= w_cnt_nxt;
      bus.E_BLK_ENA     <= w_ena_nxt;
      bus.E_BLK         <= w_blk_nxt;
      bus.E_BLK_PAR     <= w_par_nxt;
      CSR_STAT_ENC_LOCK <= (w_state_nxt == RUN);
      if (CSR_CLR) begin
        CSR_FRAME_CNT   <= '0;
        CSR_ERR_CADENCE <= 1'b0;
      end else begin
        if (w_inc) begin
          CSR_FRAME_CNT <= CSR_FRAME_CNT + 32'd1;
        end
        if (w_err) begin
          CSR_ERR_CADENCE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fec_encoder.sv
// Directed bench for fec_encoder: bypass, parity, cadence, CSR, reset.
// Frame parity is also checked by dividing the whole codeword by g(x).
module tb_fec_encoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENC_EN;
  logic        CSR_CLR;
  logic        lock;
  logic        err;
  logic [31:0] fcnt;

  int n_vec = 0;
  int n_mis = 0;

  fec_if bus();

  fec_encoder dut (
    .CLK               (CLK),
    .RST               (RST),
    .ENC_EN            (ENC_EN),
    .CSR_CLR           (CSR_CLR),
    .bus               (bus.slave),
    .CSR_STAT_ENC_LOCK (lock),
    .CSR_ERR_CADENCE   (err),
    .CSR_FRAME_CNT     (fcnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [64:0] obs,
                     input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // drive one cycle; outputs are sampled 1ns after the edge
  task automatic cyc(input logic ena, input logic [64:0] blk);
    bus.D_BLK_ENA = ena;
    bus.D_BLK     = blk;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [64:0] rnd65();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[64:0];
  endfunction

  function automatic logic [31:0] step(input logic [31:0] r,
                                       input logic b);
    return {r[30:0], 1'b0} ^ ((b ^ r[31]) ? 32'h00A0_0805 : 32'h0);
  endfunction

  // mode 0: zeros, 1: only bit 64 of block 31, 2: random
  task automatic frame(input int mode, input logic clr,
                       input logic exact, input logic [64:0] exp_par);
    logic [31:0] syn;
    logic [64:0] b;
    syn = '0;
    for (int i = 0; i < 32; i++) begin
      if (mode == 2) b = rnd65();
      else if (mode == 1 && i == 31) b = 65'h1_0000_0000_0000_0000;
      else b = 65'h0;
      cyc(1'b1, b);
      chk("dat", bus.E_BLK, b);
      chk("dat_ena", 65'(bus.E_BLK_ENA), 65'h1);
      chk("dat_par", 65'(bus.E_BLK_PAR), 65'h0);
      for (int k = 0; k < 65; k++) syn = step(syn, bus.E_BLK[k]);
    end
    CSR_CLR = clr;
    cyc(1'b0, 65'h0);
    CSR_CLR = 1'b0;
    chk("par_flag", 65'(bus.E_BLK_PAR), 65'h1);
    chk("par_ena", 65'(bus.E_BLK_ENA), 65'h1);
    chk("par_hi", 65'(bus.E_BLK[64:32]), 65'h0);
    if (exact) chk("par_val", bus.E_BLK, exp_par);
    for (int k = 0; k < 32; k++) syn = step(syn, bus.E_BLK[k]);
    chk("syndrome", 65'(syn), 65'h0);
  endtask

  initial begin
    logic [64:0] b;
    logic        e;
    RST = 1'b1;
    ENC_EN = 1'b0;
    CSR_CLR = 1'b0;
    bus.D_BLK_ENA = 1'b1;
    bus.D_BLK = 65'h1_2345_6789_ABCD_EF01;
    repeat (3) cyc(1'b1, 65'h1_2345_6789_ABCD_EF01);
    chk("rst_blk", bus.E_BLK, 65'h0);
    chk("rst_ena", 65'(bus.E_BLK_ENA), 65'h0);
    chk("rst_par", 65'(bus.E_BLK_PAR), 65'h0);
    chk("rst_lock", 65'(lock), 65'h0);
    chk("rst_err", 65'(err), 65'h0);
    chk("rst_cnt", 65'(fcnt), 65'h0);
    RST = 1'b0;

    for (int i = 0; i < 20; i++) begin
      e = 1'($urandom_range(1));
      b = rnd65();
      cyc(e, b);
      chk("byp_blk", bus.E_BLK, b);
      chk("byp_ena", 65'(bus.E_BLK_ENA), 65'(e));
      chk("byp_par", 65'(bus.E_BLK_PAR), 65'h0);
    end

    ENC_EN = 1'b1;
    b = rnd65();
    cyc(1'b1, b);
    chk("idle_byp", bus.E_BLK, b);
    cyc(1'b0, 65'h0);
    chk("align_ena", 65'(bus.E_BLK_ENA), 65'h0);
    chk("align_lock", 65'(lock), 65'h1);

    frame(0, 1'b0, 1'b1, 65'h0);
    chk("cnt_zero_frm", 65'(fcnt), 65'h1);
    frame(1, 1'b0, 1'b1, 65'h0_0000_0000_A010_0500);
    chk("cnt_bit_frm", 65'(fcnt), 65'h2);

    for (int i = 0; i < 10; i++) cyc(1'b1, rnd65());
    cyc(1'b0, 65'h0);
    chk("cad_err", 65'(err), 65'h1);
    chk("cad_lock", 65'(lock), 65'h0);
    chk("cad_ena", 65'(bus.E_BLK_ENA), 65'h0);
    chk("cad_par", 65'(bus.E_BLK_PAR), 65'h0);
    chk("cad_cnt", 65'(fcnt), 65'h2);
    cyc(1'b0, 65'h0);
    chk("relock", 65'(lock), 65'h1);
    frame(1, 1'b0, 1'b1, 65'h0_0000_0000_A010_0500);
    chk("relock_cnt", 65'(fcnt), 65'h3);
    chk("err_sticky", 65'(err), 65'h1);

    frame(0, 1'b1, 1'b1, 65'h0);
    chk("clr_cnt", 65'(fcnt), 65'h0);
    chk("clr_err", 65'(err), 65'h0);

    for (int f = 0; f < 100; f++) frame(2, 1'b0, 1'b0, 65'h0);
    chk("rt_cnt", 65'(fcnt), 65'd100);
    chk("rt_err", 65'(err), 65'h0);

    for (int i = 0; i < 5; i++) cyc(1'b1, rnd65());
    ENC_EN = 1'b0;
    b = rnd65();
    cyc(1'b1, b);
    chk("dis_blk", bus.E_BLK, b);
    chk("dis_ena", 65'(bus.E_BLK_ENA), 65'h1);
    chk("dis_par", 65'(bus.E_BLK_PAR), 65'h0);
    chk("dis_lock", 65'(lock), 65'h0);
    b = rnd65();
    cyc(1'b0, b);
    chk("dis_gap_ena", 65'(bus.E_BLK_ENA), 65'h0);
    chk("dis_gap_blk", bus.E_BLK, b);

    ENC_EN = 1'b1;
    cyc(1'b1, rnd65());
    cyc(1'b0, 65'h0);
    for (int i = 0; i < 20; i++) cyc(1'b1, rnd65());
    RST = 1'b1;
    cyc(1'b1, rnd65());
    chk("mrst_blk", bus.E_BLK, 65'h0);
    chk("mrst_ena", 65'(bus.E_BLK_ENA), 65'h0);
    chk("mrst_par", 65'(bus.E_BLK_PAR), 65'h0);
    chk("mrst_lock", 65'(lock), 65'h0);
    chk("mrst_cnt", 65'(fcnt), 65'h0);
    RST = 1'b0;
    cyc(1'b0, 65'h0);
    chk("post_rst_par", 65'(bus.E_BLK_PAR), 65'h0);
    chk("post_rst_ena", 65'(bus.E_BLK_ENA), 65'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
